// File: rtl/address_mem_encoder.sv
// address_mem_encoder
//   Small content-addressable table: maps stored addresses to entry indices.
//   Lookups are purely combinational; writes and clears act on the rising
//   clock edge. Each entry holds a valid bit and an IN_W-bit address.
//
// Ports
//   clock            : single clock, rising-edge state updates
//   reset            : asynchronous, active-low; invalidates and zeroes all entries
//   we               : store addr_in into the lowest free entry (if not present)
//   clear            : free the entry holding addr_in (takes precedence over we)
//   addr_in          : lookup / write / clear address
//   addr_out         : matching entry index, else lowest free index, else 0
//   not_selected     : high when addr_in matches no valid entry
//   address_conflict : we AND match
//   free_space       : high when at least one entry is invalid
module address_mem_encoder #(
    parameter int OUT_W = 3,
    parameter int IN_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic             clear,
    input  logic [IN_W-1:0]  addr_in,
    output logic [OUT_W-1:0] addr_out,
    output logic             not_selected,
    output logic             address_conflict,
    output logic             free_space
);

    localparam int DEPTH = 2 ** OUT_W;

    logic [DEPTH-1:0] valid;
    logic [IN_W-1:0]  mem [DEPTH];

    logic             hit;
    logic [OUT_W-1:0] hit_idx;
    logic [OUT_W-1:0] free_idx;

    // Duplicates are never stored, so at most one entry can hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (mem[i] == addr_in)) begin
                hit     = 1'b1;
                hit_idx = OUT_W'(i);
            end
        end
    end

    // Scan from the top down so the lowest invalid index wins; stays 0 when full.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = OUT_W'(i);
            end
        end
    end

    assign free_space       = ~&valid;
    assign not_selected     = ~hit;
    assign address_conflict = we & hit;
    assign addr_out         = hit ? hit_idx : free_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            // Clear wins over a simultaneous write; data bits are left in place.
            if (hit) begin
                valid[hit_idx] <= 1'b0;
            end
        end else if (we && !hit && free_space) begin
            valid[free_idx] <= 1'b1;
            mem[free_idx]   <= addr_in;
        end
    end

endmodule

// File: tb/tb_address_mem_encoder.sv
module tb_address_mem_encoder;

    localparam int OUT_W = 3;
    localparam int IN_W  = 16;

    logic             clock;
    logic             reset;
    logic             we;
    logic             clear;
    logic [IN_W-1:0]  addr_in;
    logic [OUT_W-1:0] addr_out;
    logic             not_selected;
    logic             address_conflict;
    logic             free_space;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             we;
        logic             clear;
        logic [IN_W-1:0]  addr;
        logic [OUT_W-1:0] exp_out;
        logic             exp_ns;
        logic             exp_conf;
        logic             exp_free;
    } vec_t;

    vec_t vecs[$];

    address_mem_encoder #(.OUT_W(OUT_W), .IN_W(IN_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .we               (we),
        .clear            (clear),
        .addr_in          (addr_in),
        .addr_out         (addr_out),
        .not_selected     (not_selected),
        .address_conflict (address_conflict),
        .free_space       (free_space)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void add(input logic w, input logic c, input int a,
                                input int eo, input logic ns, input logic cf,
                                input logic fr);
        vec_t v;
        v.we       = w;
        v.clear    = c;
        v.addr     = IN_W'(a);
        v.exp_out  = OUT_W'(eo);
        v.exp_ns   = ns;
        v.exp_conf = cf;
        v.exp_free = fr;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [OUT_W-1:0] eo,
                         input logic ns, input logic cf, input logic fr);
        total++;
        if (addr_out !== eo || not_selected !== ns ||
            address_conflict !== cf || free_space !== fr) begin
            bad++;
            $display("FAIL %s: got out=%0d ns=%0b conf=%0b free=%0b, want out=%0d ns=%0b conf=%0b free=%0b",
                     name, addr_out, not_selected, address_conflict, free_space,
                     eo, ns, cf, fr);
        end
    endtask

    initial begin
        we      = 1'b0;
        clear   = 1'b0;
        addr_in = '0;
        reset   = 1'b0;

        // Fill 10..80 into entries 0..7; outputs checked before each edge.
        for (int k = 0; k < 8; k++) add(1, 0, 10 * (k + 1), k, 1, 0, 1);
        add(0, 0, 80, 7, 0, 0, 0);
        add(1, 0, 80, 7, 0, 1, 0);        // conflict, no change
        add(0, 0, 10, 0, 0, 0, 0);
        add(0, 1, 60, 5, 0, 0, 0);        // clear entry 5
        add(0, 0, 60, 5, 1, 0, 1);
        add(1, 0, 90, 5, 1, 0, 1);        // reuse entry 5
        add(0, 0, 90, 5, 0, 0, 0);
        add(0, 0, 80, 7, 0, 0, 0);
        add(0, 0, 70, 6, 0, 0, 0);
        add(0, 0, 60, 0, 1, 0, 0);
        add(0, 0, 50, 4, 0, 0, 0);
        add(0, 0, 40, 3, 0, 0, 0);
        add(0, 0, 30, 2, 0, 0, 0);
        add(0, 0, 20, 1, 0, 0, 0);
        add(0, 0, 10, 0, 0, 0, 0);
        add(1, 0, 100, 0, 1, 0, 0);       // full: write dropped
        add(0, 0, 100, 0, 1, 0, 0);
        add(0, 1, 100, 0, 1, 0, 0);       // clear with no match
        add(0, 0, 10, 0, 0, 0, 0);
        add(1, 1, 10, 0, 0, 1, 0);        // clear wins over write
        add(0, 0, 10, 0, 1, 0, 1);
        add(1, 1, 120, 0, 1, 0, 1);       // no match: clear still blocks write
        add(0, 0, 120, 0, 1, 0, 1);
        add(1, 0, 110, 0, 1, 0, 1);
        add(0, 0, 110, 0, 0, 0, 0);
        add(0, 0, 90, 5, 0, 0, 0);

        // Reset state while held in reset
        #2;
        check("reset_hold", 0, 1, 0, 1);
        @(negedge clock);
        reset = 1'b1;
        #1 check("after_release", 0, 1, 0, 1);

        foreach (vecs[i]) begin
            @(negedge clock);
            we      = vecs[i].we;
            clear   = vecs[i].clear;
            addr_in = vecs[i].addr;
            #1 check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_ns,
                     vecs[i].exp_conf, vecs[i].exp_free);
        end

        // Asynchronous reset in the middle of a write, held across an edge.
        @(negedge clock);
        we      = 1'b1;
        clear   = 1'b0;
        addr_in = 16'd130;
        #2 reset = 1'b0;
        #1 check("async_reset", 0, 1, 0, 1);
        addr_in = 16'd20;
        #1 check("reset_lookup20", 0, 1, 0, 1);
        addr_in = 16'd130;
        @(posedge clock);
        #1 check("reset_beats_write", 0, 1, 0, 1);
        @(negedge clock);
        reset = 1'b1;
        we    = 1'b0;
        addr_in = 16'd0;
        #1 check("zeroed_no_match0", 0, 1, 0, 1);
        addr_in = 16'd130;
        #1 check("no_130_after_reset", 0, 1, 0, 1);

        // First edge after release is live.
        we      = 1'b1;
        addr_in = 16'd5;
        @(negedge clock);
        we = 1'b0;
        #1 check("first_write_after_reset", 0, 0, 0, 1);
        addr_in = 16'd6;
        #1 check("next_free_is_1", 1, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
